// File: rtl/spi_peripheral.sv
// -----------------------------------------------------------------------------
// spi_peripheral
//   SPI mode-0 write-only peripheral that loads five 8-bit configuration
//   registers from 16-bit frames: bit15 = R/W (1 = write), bits14:8 = address,
//   bits7:0 = data. The SPI pins are asynchronous to clk and are brought into
//   the clk domain through SYNC_STAGES-deep synchronizers; sclk and ncs get an
//   extra history flop for edge detection.
//
// Ports
//   clk              system clock, all state on rising edge
//   rst              asynchronous active-high reset
//   sclk, copi, ncs  SPI pad inputs (asynchronous)
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
//   txn_done         one-cycle pulse after an accepted write
//   txn_err          one-cycle pulse after a rejected frame
//
// There is no handshake: a frame is delimited by ncs low; the outcome is
// reported by a single-cycle pulse on txn_done or txn_err (never both), and
// read frames report nothing.
// -----------------------------------------------------------------------------
module spi_peripheral #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       txn_done,
   output logic       txn_err
);

   typedef enum logic {ST_IDLE, ST_RECV} state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_copi_sync;
   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic                   r_sclk_hist;
   logic                   r_ncs_hist;

   state_t      r_state;
   logic [15:0] r_shift;
   logic [4:0]  r_cnt;
   logic [7:0]  r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;
   logic        r_done, r_err;

   logic       w_sclk_s, w_copi_s, w_ncs_s;
   logic       w_sclk_rise, w_ncs_fall, w_ncs_rise;
   logic [6:0] w_addr;
   logic       w_is_write, w_len_ok, w_accept, w_reject;

   // ncs chain resets high and sclk low so releasing reset never looks like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '1;
         r_sclk_hist <= 1'b0;
         r_ncs_hist  <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
         r_sclk_hist <= w_sclk_s;
         r_ncs_hist  <= w_ncs_s;
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
   assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
   assign w_ncs_fall  = ~w_ncs_s & r_ncs_hist;
   assign w_ncs_rise  = w_ncs_s & ~r_ncs_hist;

   assign w_addr     = r_shift[14:8];
   assign w_is_write = r_shift[15];
   assign w_len_ok   = (r_cnt == 5'd16);
   assign w_accept   = w_len_ok & w_is_write & (w_addr <= 7'd4);
   // A well-formed read is neither accepted nor rejected.
   assign w_reject   = ~w_len_ok | (w_is_write & (w_addr > 7'd4));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_reg0  <= '0;
         r_reg1  <= '0;
         r_reg2  <= '0;
         r_reg3  <= '0;
         r_reg4  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_ncs_fall) begin
                  r_state <= ST_RECV;
                  r_shift <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_RECV: begin
               // End of frame wins over a coincident sclk edge.
               if (w_ncs_rise) begin
                  r_state <= ST_IDLE;
                  if (w_accept) begin
                     r_done <= 1'b1;
                     case (w_addr[2:0])
                        3'd0:    r_reg0 <= r_shift[7:0];
                        3'd1:    r_reg1 <= r_shift[7:0];
                        3'd2:    r_reg2 <= r_shift[7:0];
                        3'd3:    r_reg3 <= r_shift[7:0];
                        default: r_reg4 <= r_shift[7:0];
                     endcase
                  end else if (w_reject) begin
                     r_err <= 1'b1;
                  end
               end else if (w_sclk_rise) begin
                  r_shift <= {r_shift[14:0], w_copi_s};
                  // 17 marks "too many bits" and sticks there.
                  if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_reg0;
   assign en_reg_out_15_8 = r_reg1;
   assign en_reg_pwm_7_0  = r_reg2;
   assign en_reg_pwm_15_8 = r_reg3;
   assign pwm_duty_cycle  = r_reg4;
   assign txn_done        = r_done;
   assign txn_err         = r_err;

endmodule

// File: tb/tb_spi_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral
//   Directed SPI frames with hand-chosen expected outcomes. Each frame that
//   should produce a pulse pushes {kind, register image} into exp_q; a
//   separate monitor pops on every txn_done/txn_err pulse and compares.
// -----------------------------------------------------------------------------
module tb_spi_peripheral;

   localparam int PHASE = 4;  // clk periods per sclk half-period

   localparam logic [1:0] K_DONE = 2'b01;
   localparam logic [1:0] K_ERR  = 2'b10;
   localparam logic [1:0] K_NONE = 2'b00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs = 1'b1;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       txn_done, txn_err;

   int errors = 0;
   int checks = 0;

   logic [41:0] exp_q[$];
   logic [7:0]  m_reg[5];

   spi_peripheral #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done), .txn_err(txn_err)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [39:0] dut_regs();
      return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
   endfunction

   function automatic logic [39:0] model_regs();
      return {m_reg[4], m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && (txn_done || txn_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse", txn_done, txn_err);
         end else begin
            logic [41:0] e;
            e = exp_q.pop_front();
            check("pulse_kind", {62'd0, txn_err, txn_done}, {62'd0, e[41:40]});
            check("pulse_regs", {24'd0, dut_regs()}, {24'd0, e[39:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_frame();
      @(negedge clk);
      ncs = 1'b0;
      repeat (PHASE) @(negedge clk);
   endtask

   // Mode 0: data is set while sclk is low, sampled on the rise.
   task automatic shift_bits(input logic [31:0] word, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = word[i];
         sclk = 1'b0;
         repeat (PHASE) @(negedge clk);
         sclk = 1'b1;
         repeat (PHASE) @(negedge clk);
      end
      sclk = 1'b0;
      repeat (PHASE) @(negedge clk);
   endtask

   // Raise ncs; with lat_chk, txn_done must be low at edge N+1 and high at N+2,
   // where N is the first clk edge that samples ncs high.
   task automatic end_frame(input bit lat_chk);
      @(negedge clk);
      ncs = 1'b1;
      @(posedge clk);  // edge N
      if (lat_chk) begin
         @(posedge clk); #1;
         check("latency_n1_done_low", {63'd0, txn_done}, 64'd0);
         @(posedge clk); #1;
         check("latency_n2_done_high", {63'd0, txn_done}, 64'd1);
      end
   endtask

   task automatic settle_and_check(input string name);
      repeat (12) @(negedge clk);
      check({name, "_regs"}, {24'd0, dut_regs()}, {24'd0, model_regs()});
      check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   // word holds nbits MSB-first; kind is the hand-chosen outcome.
   task automatic frame(input string name, input logic [31:0] word, input int nbits,
                        input logic [1:0] kind, input bit lat_chk);
      if (kind == K_DONE) m_reg[word[10:8]] = word[7:0];
      if (kind != K_NONE) exp_q.push_back({kind, model_regs()});
      start_frame();
      shift_bits(word, nbits);
      end_frame(lat_chk);
      settle_and_check(name);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_regs", {24'd0, dut_regs()}, 64'd0);
      check("reset_pulses", {62'd0, txn_err, txn_done}, 64'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("post_reset_regs", {24'd0, dut_regs()}, 64'd0);

      frame("wr_addr0_f0",   32'h80F0, 16, K_DONE, 1'b0);
      frame("wr_addr4_80",   32'h8480, 16, K_DONE, 1'b1);
      frame("wr_addr5_err",  32'h85AA, 16, K_ERR,  1'b0);
      frame("len15_err",     32'h4099, 15, K_ERR,  1'b0);  // first 15 bits of 0x8133
      frame("len17_err",     32'h10266, 17, K_ERR, 1'b0);  // 0x8133 plus one extra bit
      frame("read_noop",     32'h0255, 16, K_NONE, 1'b0);
      frame("zero_bits_err", 32'h0,     0, K_ERR,  1'b0);
      frame("wr_addr1_55",   32'h8155, 16, K_DONE, 1'b1);
      frame("wr_addr2_a5",   32'h82A5, 16, K_DONE, 1'b0);
      frame("wr_addr4_3c",   32'h843C, 16, K_DONE, 1'b0);

      // Reset in the middle of 0x83FF; ncs is released while reset is held.
      start_frame();
      shift_bits(32'h83, 8);
      @(negedge clk);
      rst = 1'b1;
      ncs = 1'b1;
      sclk = 1'b0;
      copi = 1'b0;
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("midframe_rst_regs", {24'd0, dut_regs()}, 64'd0);
      rst = 1'b0;
      settle_and_check("after_midframe_rst");

      frame("wr_addr3_ff",   32'h83FF, 16, K_DONE, 1'b1);
      check("pwm_15_8_final", {56'd0, en_reg_pwm_15_8}, 64'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: sclk  input  1  SPI serial clock from pad, asynchronous to clk.
REQ-004 SHALL have port: copi  input  1  SPI controller-out/peripheral-in data, asynchronous.
REQ-005 SHALL have port: ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port: en_reg_out_7_0  output  8  register 0x00, output enables bits 7:0.
REQ-007 SHALL have port: en_reg_out_15_8  output  8  register 0x01, output enables bits 15:8.
REQ-008 SHALL have port: en_reg_pwm_7_0  output  8  register 0x02, PWM enables bits 7:0.
REQ-009 SHALL have port: en_reg_pwm_15_8  output  8  register 0x03, PWM enables bits 15:8.
REQ-010 SHALL have port: pwm_duty_cycle  output  8  register 0x04, shared PWM duty.
REQ-011 SHALL have port: txn_done  output  1  one-cycle pulse on accepted write.
REQ-012 SHALL have port: txn_err  output  1  one-cycle pulse on rejected frame.
REQ-013 SHALL have parameter: SYNC_STAGES, default 2, synchronizer depth for sclk/copi/ncs (min 2).

Function
REQ-014 SHALL pass sclk, copi, ncs through SYNC_STAGES flops each, plus one history flop for sclk and ncs edge detection.
REQ-015 SHALL use SPI mode 0: copi sampled on synchronized sclk rising edge; falling edges ignored.
REQ-016 SHALL implement FSM IDLE -> RECV on synchronized ncs falling edge; RECV -> IDLE on synchronized ncs rising edge.
REQ-017 SHALL, on entering RECV, clear a 16-bit shift register and a 5-bit bit counter.
REQ-018 SHALL, in RECV on each sclk rise, shift copi in MSB-first and increment counter, saturating at 17 (overflow marker).
REQ-019 SHALL ignore sclk edges while in IDLE.
REQ-020 SHALL decode frame: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-021 SHALL, on ncs rise, accept the frame iff counter == 16, bit15 == 1, and address <= 0x04.
REQ-022 SHALL, on accepted frame, write data into the addressed register on the same clk edge the FSM returns to IDLE; txn_done high for exactly the following cycle.
REQ-023 SHALL, on ncs rise with counter != 16, or write to address > 0x04, leave all registers unchanged and pulse txn_err for one cycle.
REQ-024 SHALL treat a read frame (bit15 == 0, counter == 16) as a no-op: no write, no txn_done, no txn_err.
REQ-025 SHALL hold register values between transactions; only an accepted write changes a register.
REQ-026 SHALL, with pad ncs first sampled high at clk edge N (SYNC_STAGES = 2), update the register at edge N+2.
REQ-027 SHALL operate correctly when each sclk high and low phase spans >= SYNC_STAGES+1 clk periods; faster sclk is unsupported.
REQ-028 SHALL, if ncs falls and rises with zero sclk edges, pulse txn_err (counter 0).

Reset
REQ-029 SHALL, while rst is high, force all five registers to 0x00, txn_done = 0, txn_err = 0, FSM = IDLE, counter = 0, shift register = 0.
REQ-030 SHALL reset ncs synchronizer and history flops to 1, sclk and copi flops to 0, so no spurious edge is detected at reset release.
REQ-031 SHALL, on rst asserted mid-frame, discard the partial frame; after release, write nothing until a fresh ncs falling edge.

Verification
REQ-032 SHALL cover: write frame 0x80F0 (addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0, one txn_done pulse, other registers 0x00.
REQ-033 SHALL cover: write 0x84 80 (addr 0x04, data 0x80) -> pwm_duty_cycle = 0x80, txn_done pulse 2 cycles after sampled ncs rise.
REQ-034 SHALL cover: write to addr 0x05 (frame 0x85AA) -> all registers unchanged, one txn_err pulse, no txn_done.
REQ-035 SHALL cover: 15-bit and 17-bit frames with write bit set to addr 0x01 -> en_reg_out_15_8 unchanged, txn_err pulse each.
REQ-036 SHALL cover: read frame 0x0255 -> no register change, no txn_done, no txn_err.
REQ-037 SHALL cover: rst pulsed after 8 bits of 0x83FF, then ncs released -> en_reg_pwm_15_8 = 0x00, no pulses; next full 0x83FF -> 0xFF.
